// File: rtl/aes_pkg.sv
// Shared AES definitions for the key-schedule controller.
//   AES_NR128  : round count for AES-128
//   rcon_t     : round-constant byte
//   ks_state_t : key-schedule FSM state
//   xtime()    : GF(2^8) multiply by x, reduced with 8'h1B
//   rot_word() : cyclic left rotate of a 32-bit word by one byte
package aes_pkg;

  localparam int AES_NR128 = 10;

  typedef logic [7:0] rcon_t;

  typedef enum logic [1:0] {
    KS_IDLE   = 2'd0,
    KS_EXPAND = 2'd1,
    KS_READY  = 2'd2
  } ks_state_t;

  function automatic rcon_t xtime(input rcon_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_key_round_step.sv
// One AES-128 key-expansion round, combinational.
//   prev_key : previous round key, w0 in [127:96]
//   rcon     : round constant for this step
//   next_key : following round key, same word order
module aes_key_round_step
  import aes_pkg::*;
(
  input  logic [127:0] prev_key,
  input  rcon_t        rcon,
  output logic [127:0] next_key
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot_w, sub_w, g_w;
  logic [31:0] w4, w5, w6, w7;

  assign {w0, w1, w2, w3} = prev_key;
  assign rot_w = rot_word(w3);

  for (genvar j = 0; j < 4; j++) begin : g_sbox
    aes_sbox u_sbox (
      .in_byte  (rot_w[8*j +: 8]),
      .out_byte (sub_w[8*j +: 8])
    );
  end

  assign g_w = sub_w ^ {rcon, 24'h0};
  assign w4  = w0 ^ g_w;
  assign w5  = w4 ^ w1;
  assign w6  = w5 ^ w2;
  assign w7  = w6 ^ w3;

  assign next_key = {w4, w5, w6, w7};

endmodule

// File: rtl/aes_sbox.sv
// AES forward S-box, combinational table lookup.
//   in_byte  : input byte
//   out_byte : SubBytes(in_byte)
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // Index 0 sits in the leftmost byte of the concatenation.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128 key-schedule controller.
// Loads a cipher key over valid/ready, expands one round key per cycle
// into a flop register file and serves round keys through a registered
// read port (1-cycle latency).
//   clk, rst_n             : clock, async active-low reset
//   key_in/key_valid/key_ready : cipher key load handshake
//   busy                   : expansion in progress
//   keys_ready             : round keys 0..NUM_ROUNDS valid
//   rk_req/rk_idx          : round-key read request
//   rk_valid/rk_data/rk_err: registered read response
module aes_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_NR128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic         busy,
  output logic         keys_ready,
  input  logic         rk_req,
  input  logic [3:0]   rk_idx,
  output logic         rk_valid,
  output logic [127:0] rk_data,
  output logic         rk_err
);

  localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

  ks_state_t    state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  rcon_t        rcon_q, rcon_d;
  logic [127:0] rk_q [0:NUM_ROUNDS];
  logic [127:0] rk_d [0:NUM_ROUNDS];
  logic         rk_valid_q, rk_valid_d;
  logic         rk_err_q, rk_err_d;
  logic [127:0] rk_data_q, rk_data_d;

  logic [127:0] prev_key, step_key, rd_key;
  logic         rd_hit;

  // Outputs decode registered state only: no input-to-output path.
  assign key_ready  = (state_q != KS_EXPAND);
  assign busy       = (state_q == KS_EXPAND);
  assign keys_ready = (state_q == KS_READY);
  assign rk_valid   = rk_valid_q;
  assign rk_err     = rk_err_q;
  assign rk_data    = rk_data_q;

  // Source of the current step is rk[cnt-1]; outside EXPAND this is unused.
  always_comb begin
    prev_key = '0;
    for (int i = 0; i <= NUM_ROUNDS; i++)
      if (4'(i) == cnt_q - 4'd1) prev_key = rk_q[i];
  end

  aes_key_round_step u_step (
    .prev_key (prev_key),
    .rcon     (rcon_q),
    .next_key (step_key)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rcon_d  = rcon_q;
    rk_d    = rk_q;
    case (state_q)
      KS_IDLE, KS_READY: begin
        if (key_valid) begin
          rk_d[0] = key_in;
          cnt_d   = 4'd1;
          rcon_d  = 8'h01;
          state_d = KS_EXPAND;
        end
      end
      KS_EXPAND: begin
        for (int i = 1; i <= NUM_ROUNDS; i++)
          if (4'(i) == cnt_q) rk_d[i] = step_key;
        cnt_d  = cnt_q + 4'd1;  // peaks at LAST+1 on entry to READY
        rcon_d = xtime(rcon_q);
        if (cnt_q == LAST) state_d = KS_READY;
      end
      default: state_d = KS_IDLE;
    endcase
  end

  // Read port works on pre-edge cnt, so a read coinciding with a rekey
  // still returns the old schedule.
  always_comb begin
    rd_key = '0;
    for (int i = 0; i <= NUM_ROUNDS; i++)
      if (4'(i) == rk_idx) rd_key = rk_q[i];
    rd_hit     = rk_req && (rk_idx <= LAST) && (rk_idx < cnt_q);
    rk_valid_d = rk_req;
    rk_err_d   = rk_req && !rd_hit;
    rk_data_d  = rd_hit ? rd_key : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= KS_IDLE;
      cnt_q      <= 4'd0;
      rcon_q     <= 8'h01;
      rk_valid_q <= 1'b0;
      rk_err_q   <= 1'b0;
      rk_data_q  <= '0;
      for (int i = 0; i <= NUM_ROUNDS; i++) rk_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rcon_q     <= rcon_d;
      rk_valid_q <= rk_valid_d;
      rk_err_q   <= rk_err_d;
      rk_data_q  <= rk_data_d;
      for (int i = 0; i <= NUM_ROUNDS; i++) rk_q[i] <= rk_d[i];
    end
  end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed self-checking bench for aes_key_sched_ctrl.
module tb_aes_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] key_in = '0;
  logic         key_valid = 1'b0;
  logic         key_ready, busy, keys_ready;
  logic         rk_req = 1'b0;
  logic [3:0]   rk_idx = '0;
  logic         rk_valid, rk_err;
  logic [127:0] rk_data;

  int errors = 0;
  int checks = 0;

  logic [127:0] fips [0:10];
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ZERO_RK1 = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  aes_key_sched_ctrl #(.NUM_ROUNDS(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_in     (key_in),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .busy       (busy),
    .keys_ready (keys_ready),
    .rk_req     (rk_req),
    .rk_idx     (rk_idx),
    .rk_valid   (rk_valid),
    .rk_data    (rk_data),
    .rk_err     (rk_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, ".key_ready"},  128'(key_ready),  128'd1);
    chk({tag, ".busy"},       128'(busy),       128'd0);
    chk({tag, ".keys_ready"}, 128'(keys_ready), 128'd0);
    chk({tag, ".rk_valid"},   128'(rk_valid),   128'd0);
    chk({tag, ".rk_err"},     128'(rk_err),     128'd0);
    chk({tag, ".rk_data"},    rk_data,          128'd0);
  endtask

  // One read request sampled at the next edge; response checked after it.
  task automatic rd(input string tag, input logic [3:0] idx,
                    input logic exp_err, input logic [127:0] exp_data);
    rk_req = 1'b1;
    rk_idx = idx;
    tick();
    chk({tag, ".valid"}, 128'(rk_valid), 128'd1);
    chk({tag, ".err"},   128'(rk_err),   128'(exp_err));
    chk({tag, ".data"},  rk_data,        exp_data);
    rk_req = 1'b0;
  endtask

  initial begin
    fips[0]  = FIPS_KEY;
    fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    // Reset state
    #12;
    chk_rst("reset");
    rst_n = 1'b1;
    tick();
    chk_rst("idle");
    rd("idle_rd0", 4'd0, 1'b1, '0);

    // FIPS key accept at edge E; key_valid held with junk through EXPAND
    key_in = FIPS_KEY;
    key_valid = 1'b1;
    tick();                                   // E
    key_in = {4{32'hdeadbeef}};
    chk("E.busy", 128'(busy), 128'd1);
    chk("E.key_ready", 128'(key_ready), 128'd0);
    tick();                                   // E+1
    rd("early_rd5", 4'd5, 1'b1, '0);          // sampled at E+2
    tick(); tick(); tick();                   // E+3..E+5
    rd("late_rd5", 4'd5, 1'b0, fips[5]);      // sampled at E+6
    tick(); tick();                           // E+7, E+8
    chk("E8.key_ready", 128'(key_ready), 128'd0);
    tick();                                   // E+9
    chk("E9.keys_ready", 128'(keys_ready), 128'd0);
    chk("E9.busy", 128'(busy), 128'd1);
    tick();                                   // E+10
    key_valid = 1'b0;
    chk("E10.keys_ready", 128'(keys_ready), 128'd1);
    chk("E10.busy", 128'(busy), 128'd0);
    chk("E10.key_ready", 128'(key_ready), 128'd1);

    // Back-to-back reads 0..10, then out-of-range index
    rk_req = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      rk_idx = 4'(i);
      tick();
      chk($sformatf("b2b%0d.valid", i), 128'(rk_valid), 128'd1);
      chk($sformatf("b2b%0d.err", i),   128'(rk_err),   128'd0);
      chk($sformatf("b2b%0d.data", i),  rk_data,        fips[i]);
    end
    rd("rd12", 4'd12, 1'b1, '0);
    tick();
    chk("idle_rd.valid", 128'(rk_valid), 128'd0);

    // Rekey with zero key plus simultaneous read of idx 3
    key_in = '0;
    key_valid = 1'b1;
    rd("rekey_rd3", 4'd3, 1'b0, fips[3]);
    key_valid = 1'b0;
    chk("rekey.keys_ready", 128'(keys_ready), 128'd0);
    chk("rekey.busy", 128'(busy), 128'd1);
    for (int i = 0; i < 10; i++) tick();
    chk("zero.keys_ready", 128'(keys_ready), 128'd1);
    rd("zero_rd1", 4'd1, 1'b0, ZERO_RK1);
    rd("zero_rd10", 4'd10, 1'b0, ZERO_RK10);

    // Reset in the middle of an expansion
    key_in = FIPS_KEY;
    key_valid = 1'b1;
    tick();                                   // E
    key_valid = 1'b0;
    tick(); tick(); tick();                   // E+3
    #2 rst_n = 1'b0;
    #1;
    chk_rst("midrst");
    #1 rst_n = 1'b1;
    rd("postrst_rd1", 4'd1, 1'b1, '0);

    // Fresh key after reset
    key_in = FIPS_KEY;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("fresh.keys_ready", 128'(keys_ready), 128'd1);
    rd("fresh_rd1", 4'd1, 1'b0, fips[1]);
    rd("fresh_rd10", 4'd10, 1'b0, fips[10]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_key_sched_ctrl.md
# aes_key_sched_ctrl

Iterative AES-128 key-schedule controller. It accepts a cipher key over a valid/ready handshake and expands it one round per cycle using a single round-step instance. It stores all round keys in an internal register file and serves them to the cipher datapath through a registered read port. It replaces the fully unrolled combinational expansion, trading ten cycles of setup latency for one g-function instead of ten.

## Interface
- `NUM_ROUNDS`, default 10: last round-key index generated. Legal range is 1..10, which is the RCON table range.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `key_in` in 128: cipher key, with word w0 in [127:96].
- `key_valid` in 1: `key_in` is offered.
- `key_ready` out 1: controller accepts a key. A key is loaded when `key_valid` and `key_ready` are both high at a clock edge.
- `busy` out 1: expansion in progress.
- `keys_ready` out 1: round keys 0..NUM_ROUNDS are all valid.
- `rk_req` in 1: round-key read request, one cycle wide per request.
- `rk_idx` in 4: requested round index.
- `rk_valid` out 1: `rk_data` and `rk_err` are valid this cycle.
- `rk_data` out 128: round key, in the same word order as `key_in`.
- `rk_err` out 1: request rejected (index out of range or not yet generated). `rk_data` is 0 when this is set.

## Operation
- **FSM states:** IDLE, EXPAND, READY.
  - `key_ready` = 1 in IDLE and READY, and 0 in EXPAND.
  - `busy` = 1 only in EXPAND.
  - `keys_ready` = 1 only in READY.
- **Accept (IDLE or READY):**
  - `rk[0]` ← `key_in`; `cnt` ← 1; `rcon` ← 8'h01; next state EXPAND.
  - Accepting in READY is a rekey. `keys_ready` falls at that edge.
- **EXPAND, each cycle:**
  - `rk[cnt]` ← `step(rk[cnt-1], rcon)`; `cnt` ← `cnt`+1; `rcon` ← `xtime(rcon)`, where xtime reduces with 8'h1B.
  - When the written index equals NUM_ROUNDS, the next state is READY.
  - `key_valid` is ignored in EXPAND; there is no abort.
- **step() function:**
  - `g` = `SubWord(RotWord(w3)) ^ {rcon,24'h0}`.
  - `w4` = `w0^g`, `w5` = `w4^w1`, `w6` = `w5^w2`, `w7` = `w6^w3`.
- **Read port:** `rk_req` is sampled at each edge. The response is registered and appears in the next cycle.
  - Served when `rk_idx` ≤ NUM_ROUNDS and `rk_idx` < `cnt`. The pre-edge `cnt` is used, and `cnt` = NUM_ROUNDS+1 in READY.
  - Otherwise `rk_err` = 1 and `rk_data` = 0.
  - Early reads during EXPAND of already-written indices are legal.
- **Simultaneous read and key accept:** the read uses pre-edge state, so it returns old keys. Index 0 is served if the old `cnt` exceeded 0.
- **Arithmetic:** all XOR, no carries. `cnt` is 4 bits wide and saturates at NUM_ROUNDS+1. `rk_idx` values 11..15 always give `rk_err`.

## Timing
- **Reset values:** state IDLE, `cnt` 0, `rcon` 8'h01, every `rk[i]` 0, `key_ready` 1, `busy` 0, `keys_ready` 0, `rk_valid` 0, `rk_data` 0, `rk_err` 0.
- **Expansion latency:** for a key accepted at edge E, `rk[i]` is written at edge E+i. `busy` is high from after E until E+NUM_ROUNDS. `keys_ready` is high after E+NUM_ROUNDS, which is 10 cycles for AES-128.
- **Read latency:** exactly 1 cycle. Back-to-back requests every cycle are supported.
- **Reset mid-EXPAND:** returns immediately to the reset values. The partial schedule is discarded, and reads then return `rk_err` until a new key completes.
- **Combinational paths:** one `step()` per cycle, containing 4 S-boxes plus the XOR chain. There is no combinational path from inputs to outputs.

## Structure
- **Shared package `aes_pkg`:**
  - `AES_NR128` = 10.
  - the `rcon_t` byte type.
  - `xtime()`, `rot_word()`.
  - the FSM state enum `ks_state_t`.
- **Sub-module `aes_key_round_step`:** combinational. Inputs are 128-bit prev key and 8-bit rcon; output is the 128-bit next key. It instantiates four `aes_sbox`.
- **Storage:** `rk[0:NUM_ROUNDS]` as a flop array, 128 bits each.

## Test plan
- **FIPS-197 key:** key 2b7e151628aed2a6abf7158809cf4f3c.
  - `rk_idx` 1 returns a0fafe1788542cb123a339392a6c7605.
  - `rk_idx` 10 returns d014f9a8c9ee2589e13f0cc8b6630ca6.
  - `keys_ready` rises exactly 10 cycles after accept.
- **Zero key:**
  - `rk_idx` 1 returns 62636363626363636263636362636363.
  - `rk_idx` 10 returns b4ef5bcb3e92e21123e951cf6f8f188e.
- **Early/invalid reads:** read `rk_idx` 5 at 2 cycles after accept gives `rk_err`=1 and `rk_data`=0. The same read at 6 cycles succeeds. `rk_idx` 12 in READY gives `rk_err`.
- **Handshake:**
  - `key_valid` held high during EXPAND: `key_ready`=0, and no reload occurs.
  - Rekey in READY with a simultaneous read of idx 3: the read returns the old key's `rk[3]`, then `keys_ready` drops.
- **Reset mid-expansion:** assert `rst_n`=0 at cycle 4. All outputs take their reset values. A subsequent read of idx 1 gives `rk_err`. A fresh key completes correctly.
- **Back-to-back reads:** read indices 0..10 on consecutive cycles. `rk_valid` is high for 11 consecutive cycles and the data matches the reference schedule.
